ex_mdu: RTL and testbench

Iterative RV32M multiply/divide unit, parametrised in data width, that sits beside the execute stage. The execute stage hands it one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operation. The unit stalls the front of the pipeline through the hold bus while it iterates one bit per cycle, then returns a single-cycle register write. It handles the RISC-V corner cases exactly: divide-by-zero and signed overflow, both resolved on a fast path.

---
 rtl/ex_mdu_pkg.sv | 30 +++
 rtl/ex_mdu_if.sv | 27 ++
 rtl/ex_mdu.sv | 168 ++++++++++++++++
 tb/tb_ex_mdu.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mdu_pkg.sv
// rtl/ex_mdu_pkg.sv - shared constants and types for the iterative RV32M multiply/divide unit.
package ex_mdu_pkg;

  localparam logic [2:0] HOLD_NONE = 3'b000;
  localparam logic [2:0] HOLD_ID   = 3'b011;

  localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
  localparam logic [6:0] FUNCT7_M      = 7'b0000001;

  localparam logic [2:0] INST_MUL    = 3'b000;
  localparam logic [2:0] INST_MULH   = 3'b001;
  localparam logic [2:0] INST_MULHSU = 3'b010;
  localparam logic [2:0] INST_MULHU  = 3'b011;
  localparam logic [2:0] INST_DIV    = 3'b100;
  localparam logic [2:0] INST_DIVU   = 3'b101;
  localparam logic [2:0] INST_REM    = 3'b110;
  localparam logic [2:0] INST_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_CORR = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

  function automatic logic is_m_inst(input logic [6:0] opcode, input logic [6:0] funct7);
    return (opcode == INST_TYPE_R_M) && (funct7 == FUNCT7_M);
  endfunction

endpackage

// File: rtl/ex_mdu_if.sv
// rtl/ex_mdu_if.sv - execute-stage to multiply/divide unit request/result bus.
interface ex_mdu_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] op1_i;
  logic [XLEN-1:0] op2_i;
  logic [4:0]      reg_waddr_i;
  logic            flush_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;
  logic            reg_we_o;
  logic [4:0]      reg_waddr_o;
  logic [2:0]      hold_flag_o;

  modport master (
    output start_i, op_i, op1_i, op2_i, reg_waddr_i, flush_i,
    input  busy_o, done_o, result_o, reg_we_o, reg_waddr_o, hold_flag_o
  );

  modport slave (
    input  start_i, op_i, op1_i, op2_i, reg_waddr_i, flush_i,
    output busy_o, done_o, result_o, reg_we_o, reg_waddr_o, hold_flag_o
  );
endinterface

// File: rtl/ex_mdu.sv
// rtl/ex_mdu.sv - iterative one-bit-per-cycle RV32M multiply/divide unit with a fast path
// for divide-by-zero and signed overflow.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic     clk,
  input  logic     rst,
  ex_mdu_if.slave  bus
);

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opr_q, opr_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg1_q, neg1_d, neg2_q, neg2_d;
  logic              done;
  logic [2:0]        hold;

  logic            sgn1, sgn2, is_div_in, div_zero, overflow;
  logic [XLEN-1:0] mag1, mag2, fast_res;

  always_comb begin
    sgn1 = 1'b0;
    sgn2 = 1'b0;
    case (bus.op_i)
      INST_MULH:          begin sgn1 = 1'b1; sgn2 = 1'b1; end
      INST_MULHSU:        sgn1 = 1'b1;
      INST_DIV, INST_REM: begin sgn1 = 1'b1; sgn2 = 1'b1; end
      default:            ;
    endcase
  end

  assign is_div_in = bus.op_i[2];
  assign div_zero  = is_div_in && (bus.op2_i == '0);
  assign overflow  = is_div_in && sgn1 && (bus.op1_i == {1'b1, {(XLEN-1){1'b0}}})
                     && (bus.op2_i == '1);
  // REM/REMU on divide-by-zero return the dividend; on overflow DIV returns the dividend.
  assign fast_res  = div_zero ? (bus.op_i[1] ? bus.op1_i : '1)
                              : (bus.op_i[1] ? '0 : bus.op1_i);
  assign mag1 = (sgn1 && bus.op1_i[XLEN-1]) ? -bus.op1_i : bus.op1_i;
  assign mag2 = (sgn2 && bus.op2_i[XLEN-1]) ? -bus.op2_i : bus.op2_i;

  // Multiply: conditional add of the multiplicand into the high half, then shift right.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opr_q : '0)};
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Divide: shift {rem, quot} left, trial-subtract the divisor from the partial remainder.
  logic [XLEN:0]     rem_sh, diff;
  logic [2*XLEN-1:0] div_next;
  assign rem_sh   = acc_q[2*XLEN-1:XLEN-1];
  assign diff     = rem_sh - {1'b0, opr_q};
  assign div_next = diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                               : {diff[XLEN-1:0],   acc_q[XLEN-2:0], 1'b1};

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   corr_res;
  assign prod_fix = (neg1_q ^ neg2_q) ? -acc_q : acc_q;

  always_comb begin
    corr_res = '0;
    case (op_q)
      INST_MUL:                           corr_res = prod_fix[XLEN-1:0];
      INST_MULH, INST_MULHSU, INST_MULHU: corr_res = prod_fix[2*XLEN-1:XLEN];
      INST_DIV, INST_DIVU:                corr_res = (neg1_q ^ neg2_q) ? -acc_q[XLEN-1:0]
                                                                       : acc_q[XLEN-1:0];
      default:                            corr_res = neg1_q ? -acc_q[2*XLEN-1:XLEN]
                                                            : acc_q[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opr_d    = opr_q;
    result_d = result_q;
    op_d     = op_q;
    rd_d     = rd_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    done     = 1'b0;
    hold     = HOLD_NONE;
    if (bus.flush_i) begin
      state_d = MDU_IDLE;
    end else begin
      case (state_q)
        MDU_IDLE: begin
          if (bus.start_i) begin
            hold   = HOLD_ID;
            op_d   = bus.op_i;
            rd_d   = bus.reg_waddr_i;
            neg1_d = sgn1 && bus.op1_i[XLEN-1];
            neg2_d = sgn2 && bus.op2_i[XLEN-1];
            if (div_zero || overflow) begin
              acc_d   = {{XLEN{1'b0}}, fast_res};
              state_d = MDU_DONE;
            end else begin
              acc_d   = {{XLEN{1'b0}}, mag1};
              opr_d   = mag2;
              cnt_d   = CNT_W'(XLEN);
              state_d = MDU_CALC;
            end
          end
        end
        MDU_CALC: begin
          hold = HOLD_ID;
          if (cnt_q == '0) begin
            state_d = MDU_CORR;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
            acc_d = op_q[2] ? div_next : mul_next;
          end
        end
        MDU_CORR: begin
          hold    = HOLD_ID;
          acc_d   = {acc_q[2*XLEN-1:XLEN], corr_res};
          state_d = MDU_DONE;
        end
        default: begin
          done     = 1'b1;
          result_d = acc_q[XLEN-1:0];
          state_d  = MDU_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= MDU_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opr_q    <= '0;
      result_q <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opr_q    <= opr_d;
      result_q <= result_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
    end
  end

  // The final result sits in the low accumulator half during DONE and is retained afterwards.
  assign bus.result_o    = (state_q == MDU_DONE) ? acc_q[XLEN-1:0] : result_q;
  assign bus.done_o      = done;
  assign bus.reg_we_o    = done;
  assign bus.reg_waddr_o = rd_q;
  assign bus.busy_o      = (state_q != MDU_IDLE);
  assign bus.hold_flag_o = hold;

endmodule

// File: tb/tb_ex_mdu.sv
// tb/tb_ex_mdu.sv - self-checking bench for ex_mdu: directed table, corner sequences, random vs model.
module tb_ex_mdu;

  localparam logic [2:0] T_HOLD_NONE = 3'b000;
  localparam logic [2:0] T_HOLD_ID   = 3'b011;
  localparam int         NORM_LAT    = 34;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_mdu_if #(.XLEN(32)) bus();
  ex_mdu #(.XLEN(32)) dut (.clk(clk), .rst(rst_n), .bus(bus));

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      3'd6: return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
      default: return (b == 0) ? a : 32'(ua % ub);
    endcase
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i = op;
    bus.op1_i = a;
    bus.op2_i = b;
    bus.reg_waddr_i = rd;
    #1 check("hold_on_start", bus.hold_flag_o, T_HOLD_ID);
    @(posedge clk);
    #1 bus.start_i = 1'b0;
  endtask

  task automatic wait_done(output int edges);
    bit hold_ok;
    hold_ok = 1'b1;
    edges = 0;
    while (bus.done_o !== 1'b1 && edges < 100) begin
      if (bus.hold_flag_o !== T_HOLD_ID || bus.busy_o !== 1'b1) hold_ok = 1'b0;
      @(posedge clk);
      #1 edges++;
    end
    check("hold_busy_calc", hold_ok, 1);
    check("done_seen", bus.done_o, 1);
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1 if (bus.done_o === 1'b1 || bus.reg_we_o === 1'b1) n++;
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, n;
    logic [2:0] rop;
    logic [31:0] ra, rb, rexp;
    int sel, rlat;

    vecs[0]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, NORM_LAT};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000, NORM_LAT};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, NORM_LAT};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,         5'd4,  32'hFFFF_FFFF, NORM_LAT};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         5'd5,  32'hFFFF_FFFD, NORM_LAT};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFF, NORM_LAT};
    vecs[6]  = '{3'd5, 32'd5,         32'd0,         5'd7,  32'hFFFF_FFFF, 0};
    vecs[7]  = '{3'd7, 32'd5,         32'd0,         5'd8,  32'd5,         0};
    vecs[8]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'h8000_0000, 0};
    vecs[9]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h0,         0};
    vecs[10] = '{3'd5, 32'd100,       32'd7,         5'd11, 32'd14,        NORM_LAT};
    vecs[11] = '{3'd7, 32'd100,       32'd7,         5'd12, 32'd2,         NORM_LAT};
    vecs[12] = '{3'd4, 32'd0,         32'd0,         5'd13, 32'hFFFF_FFFF, 0};
    vecs[13] = '{3'd6, 32'hFFFF_FFF9, 32'd0,         5'd14, 32'hFFFF_FFF9, 0};
    vecs[14] = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 32'd1,         NORM_LAT};

    bus.start_i = 1'b0;
    bus.op_i = 3'd0;
    bus.op1_i = '0;
    bus.op2_i = '0;
    bus.reg_waddr_i = '0;
    bus.flush_i = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy_o, 0);
    check("rst_done", bus.done_o, 0);
    check("rst_we", bus.reg_we_o, 0);
    check("rst_result", bus.result_o, 0);
    check("rst_waddr", bus.reg_waddr_o, 0);
    check("rst_hold", bus.hold_flag_o, T_HOLD_NONE);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd);
      wait_done(lat);
      check($sformatf("vec%0d_result", i), bus.result_o, vecs[i].res);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_waddr", i), bus.reg_waddr_o, vecs[i].rd);
      check($sformatf("vec%0d_we", i), bus.reg_we_o, 1);
      check($sformatf("vec%0d_hold_done", i), bus.hold_flag_o, T_HOLD_NONE);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_result_held", i), bus.result_o, vecs[i].res);
      check($sformatf("vec%0d_done_pulse", i), bus.done_o, 0);
    end

    // Flush at cycle 10 of a DIV, then a MUL must run normally.
    issue(3'd4, 32'd1000, 32'd7, 5'd9);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    bus.flush_i = 1'b1;
    #1;
    check("flush_hold_released", bus.hold_flag_o, T_HOLD_NONE);
    check("flush_no_done", bus.done_o, 0);
    @(posedge clk);
    #1 bus.flush_i = 1'b0;
    check("flush_idle", bus.busy_o, 0);
    count_dones(40, n);
    check("flush_no_late_done", n, 0);
    issue(3'd0, 32'd3, 32'd4, 5'd3);
    wait_done(lat);
    check("post_flush_mul", bus.result_o, 12);
    check("post_flush_lat", lat, NORM_LAT);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a multiply.
    issue(3'd0, 32'd5, 32'd6, 5'd4);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_busy", bus.busy_o, 0);
    check("midrst_done", bus.done_o, 0);
    check("midrst_we", bus.reg_we_o, 0);
    check("midrst_result", bus.result_o, 0);
    check("midrst_waddr", bus.reg_waddr_o, 0);
    check("midrst_hold", bus.hold_flag_o, T_HOLD_NONE);
    @(negedge clk) rst_n = 1'b1;
    count_dones(40, n);
    check("midrst_no_done", n, 0);

    // A start pulse during CALC must be ignored.
    issue(3'd0, 32'd9, 32'd11, 5'd7);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i = 3'd5;
    bus.op1_i = 32'd50;
    bus.op2_i = 32'd0;
    bus.reg_waddr_i = 5'd20;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    wait_done(lat);
    check("ignore_start_result", bus.result_o, 99);
    check("ignore_start_waddr", bus.reg_waddr_o, 7);
    count_dones(40, n);
    check("ignore_start_single_done", n, 0);

    for (int k = 0; k < 40; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin
        ra = 32'h8000_0000;
        rb = 32'hFFFF_FFFF;
      end else if (sel == 2) rb = 32'($urandom_range(1, 15));
      else rb = $urandom;
      rexp = model(rop, ra, rb);
      rlat = (rop[2] && (rb == 0 || (!rop[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)))
             ? 0 : NORM_LAT;
      issue(rop, ra, rb, 5'(k));
      wait_done(lat);
      if (bus.result_o !== rexp || lat != rlat) begin
        $display("FAIL rand%0d op=%0d a=%h b=%h: got %h lat %0d expected %h lat %0d",
                 k, rop, ra, rb, bus.result_o, lat, rexp, rlat);
        fails++;
      end
      tests++;
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
